// File: rtl/digital_theremin_touch_pkg.sv
// Shared definitions for the touch panel controller: FSM states, register map
// addresses and the STATUS register bit layout.
package digital_theremin_touch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT_BUSY,
        ST_READ,
        ST_TAIL
    } state_t;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_RESULT = 2'd2;

    localparam int STAT_ACTIVE  = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_OVERRUN = 3;

    localparam int CMD_BITS     = 8;
    localparam int RESULT_BITS  = 12;
    localparam int TAIL_PERIODS = 4;

    function automatic logic [31:0] status_word(input logic active, input logic done,
                                                input logic timeout, input logic overrun);
        logic [31:0] w;
        w = '0;
        w[STAT_ACTIVE]  = active;
        w[STAT_DONE]    = done;
        w[STAT_TIMEOUT] = timeout;
        w[STAT_OVERRUN] = overrun;
        return w;
    endfunction

endpackage

// File: rtl/digital_theremin_sync2.sv
// Two-flop synchronizer bringing the touch controller's asynchronous BUSY into the clk domain.
module digital_theremin_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/digital_theremin_touch_panel_ctrl.sv
// Avalon-MM slave driving an SPI touch controller: shifts out an 8-bit command,
// waits for BUSY release, reads a 12-bit conversion and clocks 4 trailing periods.
module digital_theremin_touch_panel_ctrl
    import digital_theremin_touch_pkg::*;
#(
    parameter int CLK_DIV      = 25,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    input  logic        busy_in
);

    localparam logic [7:0]  DIV_LAST     = 8'(CLK_DIV - 1);
    localparam logic [8:0]  GUARD_LOAD   = 9'(2 * CLK_DIV);
    localparam logic [15:0] TIMEOUT_LAST = 16'(BUSY_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] wait_cnt;
    logic [8:0]  guard_cnt;
    logic [7:0]  cmd_reg;
    logic [11:0] rx_shift;
    logic [11:0] result_reg;
    logic        done_f;
    logic        timeout_f;
    logic        overrun_f;
    logic        busy_sync;

    logic        cmd_wr;
    logic        status_wr;
    logic        accept;
    logic        half_end;
    logic        sclk_rise;
    logic        period_end;
    logic        unused_wdata;

    digital_theremin_sync2 u_busy_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (busy_in),
        .q       (busy_sync)
    );

    assign cmd_wr     = chipselect && !write_n && (address == ADDR_CMD);
    assign status_wr  = chipselect && !write_n && (address == ADDR_STATUS);
    // The post-transfer guard interval is part of IDLE but still refuses new commands.
    assign accept     = cmd_wr && (state == ST_IDLE) && (guard_cnt == 9'd0);
    assign half_end   = (div_cnt == DIV_LAST);
    assign sclk_rise  = half_end && !spi_sclk;
    assign period_end = half_end && spi_sclk;
    assign unused_wdata = ^writedata[31:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            guard_cnt  <= '0;
            cmd_reg    <= '0;
            rx_shift   <= '0;
            result_reg <= '0;
            done_f     <= 1'b0;
            timeout_f  <= 1'b0;
            overrun_f  <= 1'b0;
        end else begin
            // Clears come first so a set event later in this block wins.
            if (status_wr) begin
                if (writedata[STAT_DONE])    done_f    <= 1'b0;
                if (writedata[STAT_TIMEOUT]) timeout_f <= 1'b0;
                if (writedata[STAT_OVERRUN]) overrun_f <= 1'b0;
            end
            if (cmd_wr && !accept) overrun_f <= 1'b1;

            if (state == ST_IDLE) begin
                if (guard_cnt != 9'd0) guard_cnt <= guard_cnt - 9'd1;
                if (accept) begin
                    cmd_reg   <= writedata[7:0];
                    done_f    <= 1'b0;
                    timeout_f <= 1'b0;
                    state     <= ST_CMD;
                    spi_cs_n  <= 1'b0;
                    spi_sclk  <= 1'b0;
                    spi_mosi  <= writedata[7];
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                    wait_cnt  <= '0;
                end
            end else begin
                if (half_end) begin
                    div_cnt  <= '0;
                    spi_sclk <= ~spi_sclk;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end

                if (sclk_rise && (state == ST_READ))
                    rx_shift <= {rx_shift[10:0], spi_miso};

                if (period_end) begin
                    case (state)
                        ST_CMD: begin
                            if (bit_cnt == 4'(CMD_BITS - 1)) begin
                                state    <= ST_WAIT_BUSY;
                                spi_mosi <= 1'b0;
                                bit_cnt  <= '0;
                            end else begin
                                spi_mosi <= cmd_reg[3'd6 - bit_cnt[2:0]];
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                        ST_WAIT_BUSY: begin
                            if (!busy_sync) begin
                                state   <= ST_READ;
                                bit_cnt <= '0;
                            end else if (wait_cnt == TIMEOUT_LAST) begin
                                timeout_f <= 1'b1;
                                spi_cs_n  <= 1'b1;
                                state     <= ST_IDLE;
                                guard_cnt <= GUARD_LOAD;
                            end else begin
                                wait_cnt <= wait_cnt + 16'd1;
                            end
                        end
                        ST_READ: begin
                            if (bit_cnt == 4'(RESULT_BITS - 1)) begin
                                state   <= ST_TAIL;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        ST_TAIL: begin
                            if (bit_cnt == 4'(TAIL_PERIODS - 1)) begin
                                result_reg <= rx_shift;
                                done_f     <= 1'b1;
                                spi_cs_n   <= 1'b1;
                                state      <= ST_IDLE;
                                guard_cnt  <= GUARD_LOAD;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_CMD:    readdata <= {24'd0, cmd_reg};
                ADDR_STATUS: readdata <= status_word(state != ST_IDLE, done_f, timeout_f, overrun_f);
                ADDR_RESULT: readdata <= {20'd0, result_reg};
                default:     readdata <= '0;
            endcase
        end
    end

endmodule

// File: doc/digital_theremin_touch_panel_ctrl.md
DIGITAL_THEREMIN_TOUCH_PANEL_CTRL -- requirements
Module: digital_theremin_touch_panel_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 25: clk cycles per SCLK half-period, legal range 2..255.
REQ-002 Parameter BUSY_TIMEOUT, default 16: maximum SCLK periods spent waiting for busy release.
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port address  input  2  Avalon-MM register select.
REQ-006 Port chipselect  input  1  Avalon-MM slave select.
REQ-007 Port write_n  input  1  Avalon-MM write strobe, active-low; a write occurs when chipselect=1 and write_n=0.
REQ-008 Port writedata  input  32  Avalon-MM write data.
REQ-009 Port readdata  output  32  Avalon-MM read data, registered.
REQ-010 Port spi_cs_n  output  1  touch controller chip select, active-low.
REQ-011 Port spi_sclk  output  1  serial clock, idles low (SPI mode 0).
REQ-012 Port spi_mosi  output  1  serial command data, MSB first.
REQ-013 Port spi_miso  input  1  serial conversion data, MSB first.
REQ-014 Port busy_in  input  1  touch controller BUSY, asynchronous, active-high.

Function
REQ-015 Register map SHALL be: 0 CMD (W: bits[7:0] command; R: last command); 1 STATUS (R: bit0 active, bit1 done, bit2 timeout, bit3 overrun; W: write 1 to bits[3:1] clears them); 2 RESULT (R: bits[11:0], upper bits 0); 3 reserved (R: 0, W: ignored).
REQ-016 readdata SHALL update every clk cycle to the register selected by address, one cycle after the address is presented, unqualified by chipselect.
REQ-017 A CMD write while IDLE SHALL latch the command, clear done/timeout, and enter CMD on the next cycle with spi_cs_n=0.
REQ-018 A CMD write while not IDLE SHALL be ignored except for setting overrun.
REQ-019 State machine SHALL be IDLE -> CMD -> WAIT_BUSY -> READ -> TAIL -> IDLE; active=1 in every state except IDLE.
REQ-020 Each SCLK period SHALL be 2*CLK_DIV clk cycles, low half first; MOSI changes only while SCLK is low; MISO is sampled on the clk cycle SCLK rises.
REQ-021 CMD SHALL shift out 8 command bits in 8 SCLK periods; spi_mosi=0 in all other states.
REQ-022 busy_in SHALL pass through a 2-flop synchronizer before use.
REQ-023 WAIT_BUSY SHALL issue SCLK periods, sample synchronized busy at the end of each period, and go to READ when it is 0.
REQ-024 If busy is still 1 after BUSY_TIMEOUT periods, the FSM SHALL set timeout, leave RESULT unchanged, deassert spi_cs_n, and return to IDLE.
REQ-025 READ SHALL capture 12 MISO bits MSB first in 12 SCLK periods.
REQ-026 TAIL SHALL issue 4 further SCLK periods, load RESULT, set done, and deassert spi_cs_n in the same cycle it returns to IDLE.
REQ-027 spi_cs_n SHALL stay high for at least one full SCLK period between transfers; a CMD write during that guard interval counts as not IDLE.
REQ-028 A STATUS clear write coinciding with a set event SHALL leave the flag set.

Reset
REQ-029 On reset_n=0: FSM=IDLE; spi_cs_n=1; spi_sclk=0; spi_mosi=0; readdata=0; CMD, RESULT and all STATUS bits=0; synchronizer flops=0.
REQ-030 Reset asserted mid-transfer SHALL abort immediately to the state in REQ-029 without completing the current SCLK period.

Structure
REQ-031 State encoding, register address constants and STATUS bit indices SHALL live in a shared package digital_theremin_touch_pkg.
REQ-032 The busy synchronizer SHALL be the sub-module digital_theremin_sync2; SCLK divider, shifters and FSM stay in the top module.

Verification
REQ-033 CLK_DIV=2, write CMD=0x90, busy low after 1 period, MISO model 0xA5C -> MOSI shows 10010000, RESULT=0x0A5C, done=1, cs_n high after 25 SCLK periods.
REQ-034 busy held high permanently -> timeout=1 after 16 WAIT_BUSY periods, RESULT unchanged, active=0.
REQ-035 Second CMD write (0xD0) during an active transfer -> overrun=1, CMD still reads 0x90, transfer completes normally.
REQ-036 Reset pulsed during READ -> spi_cs_n=1 and spi_sclk=0 asynchronously, all registers read 0.
REQ-037 Write 0xE to STATUS after done/timeout/overrun set -> all three read 0; write coinciding with done being set -> done reads 1.
REQ-038 Read address 3 and address 2 on consecutive cycles -> readdata=0, then RESULT one cycle later.
